// File: rtl/mem_phase_arb_if.sv
// Shared-memory phase arbiter bus: sequencer control, phase strobes,
// core and DMA request channels, and the memory data port.
interface mem_phase_arb_if;
  logic        run;
  logic        i1re, i2re, dre, gwe;
  logic [1:0]  phase;

  logic        c_req, c_we;
  logic [15:0] c_addr, c_wdata;
  logic        c_stall, c_ack;
  logic [15:0] c_rdata;

  logic        m_req, m_we;
  logic [15:0] m_addr, m_wdata;
  logic        m_ack;
  logic [15:0] m_rdata;

  logic [15:0] daddr, din, dout;
  logic        dwe;

  modport slave (
    input  run, c_req, c_we, c_addr, c_wdata, m_req, m_we, m_addr, m_wdata, dout,
    output i1re, i2re, dre, gwe, phase, c_stall, c_ack, c_rdata, m_ack, m_rdata,
           daddr, din, dwe
  );

  modport master (
    output run, c_req, c_we, c_addr, c_wdata, m_req, m_we, m_addr, m_wdata, dout,
    input  i1re, i2re, dre, gwe, phase, c_stall, c_ack, c_rdata, m_ack, m_rdata,
           daddr, din, dwe
  );
endinterface

// File: rtl/mem_phase_arb.sv
// Four-phase memory sequencer with core-priority data-window arbitration
// and a bounded deferral counter that guarantees the DMA eventual service.
module mem_phase_arb #(
  parameter int unsigned MAX_DEFER = 4
) (
  input  logic           idclk,
  input  logic           rst,
  mem_phase_arb_if.slave bus
);
  localparam logic [2:0] S_HALT = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_P1   = 3'd2;
  localparam logic [2:0] S_P2   = 3'd3;
  localparam logic [2:0] S_P3   = 3'd4;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  localparam logic [3:0] DEFER_MAX = 4'(MAX_DEFER);

  logic [2:0]  state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [3:0]  defer_q, defer_d;
  logic        we_q, we_d;
  logic        stall_q, stall_d;
  logic [15:0] daddr_q, daddr_d;
  logic [15:0] din_q, din_d;
  logic [15:0] c_rdata_q, c_rdata_d;
  logic [15:0] m_rdata_q, m_rdata_d;
  logic        c_ack_q, c_ack_d;
  logic        m_ack_q, m_ack_d;

  logic        dma_win, core_win;

  // The DMA only wins a window it is actually asking for; the core keeps
  // priority until the deferral bound is reached.
  assign dma_win  = bus.m_req && (!bus.c_req || (defer_q == DEFER_MAX));
  assign core_win = bus.c_req && !dma_win;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    defer_d   = defer_q;
    we_d      = we_q;
    stall_d   = stall_q;
    daddr_d   = daddr_q;
    din_d     = din_q;
    c_rdata_d = c_rdata_q;
    m_rdata_d = m_rdata_q;
    c_ack_d   = 1'b0;
    m_ack_d   = 1'b0;

    case (state_q)
      S_HALT: if (bus.run) state_d = S_P0;
      S_P0:   state_d = S_P1;
      S_P1: begin
        state_d = S_P2;
        stall_d = bus.c_req && dma_win;
        if (dma_win) begin
          owner_d = OWN_DMA;
          daddr_d = bus.m_addr;
          din_d   = bus.m_wdata;
          we_d    = bus.m_we;
          defer_d = 4'd0;
        end else if (core_win) begin
          owner_d = OWN_CORE;
          daddr_d = bus.c_addr;
          din_d   = bus.c_wdata;
          we_d    = bus.c_we;
          if (bus.m_req) defer_d = defer_q + 4'd1;
        end else begin
          owner_d = OWN_NONE;
          we_d    = 1'b0;
        end
      end
      S_P2:   state_d = S_P3;
      S_P3: begin
        state_d = bus.run ? S_P0 : S_HALT;
        // Read data is captured for writes too; the requester may ignore it.
        if (owner_q == OWN_CORE) begin
          c_rdata_d = bus.dout;
          c_ack_d   = 1'b1;
        end else if (owner_q == OWN_DMA) begin
          m_rdata_d = bus.dout;
          m_ack_d   = 1'b1;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge idclk) begin
    if (rst) begin
      state_q   <= S_HALT;
      owner_q   <= OWN_NONE;
      defer_q   <= 4'd0;
      we_q      <= 1'b0;
      stall_q   <= 1'b0;
      daddr_q   <= 16'd0;
      din_q     <= 16'd0;
      c_rdata_q <= 16'd0;
      m_rdata_q <= 16'd0;
      c_ack_q   <= 1'b0;
      m_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      defer_q   <= defer_d;
      we_q      <= we_d;
      stall_q   <= stall_d;
      daddr_q   <= daddr_d;
      din_q     <= din_d;
      c_rdata_q <= c_rdata_d;
      m_rdata_q <= m_rdata_d;
      c_ack_q   <= c_ack_d;
      m_ack_q   <= m_ack_d;
    end
  end

  always_comb begin
    bus.phase = 2'd0;
    case (state_q)
      S_P1:    bus.phase = 2'd1;
      S_P2:    bus.phase = 2'd2;
      S_P3:    bus.phase = 2'd3;
      default: bus.phase = 2'd0;
    endcase
  end

  assign bus.i1re    = (state_q == S_P0);
  assign bus.i2re    = (state_q == S_P1);
  assign bus.dre     = (state_q == S_P2);
  assign bus.gwe     = (state_q == S_P3);
  assign bus.dwe     = (state_q == S_P2) && we_q;
  assign bus.c_stall = stall_q && ((state_q == S_P2) || (state_q == S_P3));
  assign bus.daddr   = daddr_q;
  assign bus.din     = din_q;
  assign bus.c_ack   = c_ack_q;
  assign bus.m_ack   = m_ack_q;
  assign bus.c_rdata = c_rdata_q;
  assign bus.m_rdata = m_rdata_q;
endmodule

// File: tb/tb_mem_phase_arb.sv
// Directed bench for mem_phase_arb: stimulus pushes expected acks into a
// scoreboard, a negedge monitor pops and compares them as they appear.
module tb_mem_phase_arb;
  logic idclk = 1'b0;
  logic rst   = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  mem_phase_arb_if bus();

  mem_phase_arb #(.MAX_DEFER(4)) dut (
    .idclk (idclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 idclk = ~idclk;
  always @(posedge idclk) cyc <= cyc + 1;

  typedef struct {
    logic        is_dma;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Memory model: write in P2 with dwe, read data presented the cycle after dre.
  logic [15:0] mem [0:1023];
  always @(posedge idclk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
      mem[10'h200] <= 16'h1234;
      bus.dout     <= 16'h0000;
    end else begin
      if (bus.dwe) mem[bus.daddr[9:0]] <= bus.din;
      if (bus.dre) bus.dout <= mem[bus.daddr[9:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge idclk);
    #1;
  endtask

  task automatic push(input logic is_dma, input logic [15:0] rdata, input int at_cyc);
    exp_t e;
    e.is_dma = is_dma;
    e.rdata  = rdata;
    e.cyc    = at_cyc;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, {bus.i1re, bus.i2re, bus.dre, bus.gwe}, 0);
    check({tag, "_phase"},   bus.phase, 0);
    check({tag, "_dwe"},     bus.dwe, 0);
    check({tag, "_stall"},   bus.c_stall, 0);
    check({tag, "_acks"},    {bus.c_ack, bus.m_ack}, 0);
    check({tag, "_daddr"},   bus.daddr, 0);
    check({tag, "_din"},     bus.din, 0);
    check({tag, "_c_rdata"}, bus.c_rdata, 0);
    check({tag, "_m_rdata"}, bus.m_rdata, 0);
  endtask

  always @(negedge idclk) begin
    if (bus.c_ack === 1'b1 || bus.m_ack === 1'b1) begin
      if (bus.c_ack === 1'b1 && bus.m_ack === 1'b1) begin
        check("both_acks", 2'b11, 2'b01);
      end else if (sb.size() == 0) begin
        check("unexpected_ack", {bus.c_ack, bus.m_ack}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_owner", bus.m_ack, e.is_dma);
        check("ack_rdata", bus.m_ack ? bus.m_rdata : bus.c_rdata, e.rdata);
        check("ack_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d acks pending expected 0", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 0;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.m_req = 0; bus.m_we = 0; bus.m_addr = 0; bus.m_wdata = 0;

    // Reset state
    repeat (2) tick();
    check_reset_outputs("reset");

    // Rotation: HALT for one cycle after reset, then P0..P3 repeating
    rst = 0;
    bus.run = 1;
    check("halt_cycle_strobes", {bus.i1re, bus.i2re, bus.dre, bus.gwe}, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      logic [3:0] exp_strb;
      exp_strb = 4'b1000 >> (i % 4);
      check("rot_strobes", {bus.i1re, bus.i2re, bus.dre, bus.gwe}, exp_strb);
      check("rot_phase", bus.phase, i % 4);
      tick();
    end

    // Core write 0x0010 <- 0xBEEF (now in P0)
    bus.c_req = 1; bus.c_we = 1; bus.c_addr = 16'h0010; bus.c_wdata = 16'hBEEF;
    push(1'b0, 16'h0000, cyc + 4);
    tick(); tick();
    check("cw_p2_dwe",   bus.dwe, 1);
    check("cw_p2_daddr", bus.daddr, 16'h0010);
    check("cw_p2_din",   bus.din, 16'hBEEF);
    check("cw_p2_stall", bus.c_stall, 0);
    tick();
    check("cw_p3_dwe", bus.dwe, 0);
    check("cw_p3_gwe", bus.gwe, 1);
    tick();
    check("cw_ack_p0", {bus.c_ack, bus.i1re}, 2'b11);
    bus.c_req = 0; bus.c_we = 0;

    // DMA read 0x0200 (preloaded 0x1234)
    bus.m_req = 1; bus.m_we = 0; bus.m_addr = 16'h0200;
    push(1'b1, 16'h1234, cyc + 4);
    tick(); tick();
    check("dr_p2_daddr", bus.daddr, 16'h0200);
    check("dr_p2_dwe",   bus.dwe, 0);
    tick(); tick();
    check("dr_acks", {bus.c_ack, bus.m_ack}, 2'b01);
    bus.m_req = 0;

    // Core read back of the earlier write
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 16'h0010;
    push(1'b0, 16'hBEEF, cyc + 4);
    repeat (4) tick();
    bus.c_req = 0;

    // Both requesting: core wins 4 windows, DMA the 5th, pattern repeats
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 16'h0010;
    bus.m_req = 1; bus.m_we = 0; bus.m_addr = 16'h0200;
    for (int k = 0; k < 10; k++) begin
      logic d;
      d = (k % 5) == 4;
      push(d, d ? 16'h1234 : 16'hBEEF, cyc + 4 * (k + 1));
    end
    for (int k = 0; k < 10; k++) begin
      logic d;
      d = (k % 5) == 4;
      tick(); tick();
      check("defer_p2_stall", bus.c_stall, d);
      check("defer_p2_daddr", bus.daddr, d ? 16'h0200 : 16'h0010);
      tick();
      check("defer_p3_stall", bus.c_stall, d);
      tick();
      check("defer_p0_stall", bus.c_stall, 0);
    end
    bus.c_req = 0; bus.m_req = 0;

    // run dropped in P1: rotation completes, ack lands in HALT
    bus.c_req = 1; bus.c_we = 1; bus.c_addr = 16'h0020; bus.c_wdata = 16'h5A5A;
    push(1'b0, 16'h0000, cyc + 4);
    tick();
    bus.run = 0;
    tick();
    check("rd_p2", {bus.dre, bus.dwe}, 2'b11);
    check("rd_p2_din", bus.din, 16'h5A5A);
    tick();
    check("rd_p3_gwe", bus.gwe, 1);
    tick();
    check("rd_halt_strobes", {bus.i1re, bus.i2re, bus.dre, bus.gwe}, 0);
    check("rd_halt_phase", bus.phase, 0);
    check("rd_halt_ack", bus.c_ack, 1);
    bus.c_req = 0; bus.c_we = 0;
    tick();
    check("rd_halt2_strobes", {bus.i1re, bus.i2re, bus.dre, bus.gwe}, 0);
    check("rd_halt2_ack", bus.c_ack, 0);

    // Reset during P2 of a core write: dropped, no ack
    bus.run = 1;
    tick();
    check("rs_p0", bus.i1re, 1);
    bus.c_req = 1; bus.c_we = 1; bus.c_addr = 16'h0030; bus.c_wdata = 16'h1111;
    tick(); tick();
    check("rs_p2_dwe", bus.dwe, 1);
    rst = 1;
    tick();
    check_reset_outputs("rst_mid");
    tick();
    check("rst_mid_no_ack", bus.c_ack, 0);
    rst = 0; bus.run = 0; bus.c_req = 0; bus.c_we = 0;
    repeat (3) tick();
    check("rst_after_strobes", {bus.i1re, bus.i2re, bus.dre, bus.gwe}, 0);
    check("sb_pending", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_phase_arb.md
MEM_PHASE_ARB -- requirements
Module: mem_phase_arb

Interface
REQ-001 Parameter: MAX_DEFER, default 4, meaning consecutive data windows the DMA requester may lose to the core before it is forced a grant (range 1..15).
REQ-002 idclk  in  1  single clock; all state updates on posedge idclk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 run  in  1  enable for the phase sequencer.
REQ-005 i1re, i2re, dre, gwe  out  1 each  one-hot memory phase strobes to the shared memory.
REQ-006 phase  out  2  current phase index (0..3); 0 while halted.
REQ-007 c_req, c_we  in  1 each  core data request and write flag.
REQ-008 c_addr, c_wdata  in  16 each  core address and write data.
REQ-009 c_stall  out  1  core request deferred in the current window.
REQ-010 c_ack  out  1  core transaction complete; one-cycle pulse.
REQ-011 c_rdata  out  16  core read data, valid with c_ack.
REQ-012 m_req, m_we  in  1 each  DMA/loader data request and write flag.
REQ-013 m_addr, m_wdata  in  16 each  DMA address and write data.
REQ-014 m_ack  out  1  DMA transaction complete; one-cycle pulse.
REQ-015 m_rdata  out  16  DMA read data, valid with m_ack.
REQ-016 daddr, din  out  16 each  memory data-port address and write data (registered).
REQ-017 dwe  out  1  memory data-port write enable.
REQ-018 dout  in  16  memory data-port read data, valid the cycle after dre.

Function
REQ-019 The state machine SHALL have states HALT, P0, P1, P2, P3; transitions: HALT->P0 when run=1, otherwise stay in HALT; P0->P1->P2->P3 unconditionally; P3->P0 when run=1, else P3->HALT.
REQ-020 A run deassertion in P0..P2 SHALL NOT interrupt the rotation; the sequencer completes through P3 before halting.
REQ-021 Strobes SHALL decode from state: i1re=P0, i2re=P1, dre=P2, gwe=P3; all 0 in HALT; exactly one high in P0..P3.
REQ-022 Arbitration SHALL be sampled in P1 and the result registered on the P1->P2 edge as owner (NONE/CORE/DMA), together with the owner's addr, wdata, and we into daddr, din, and a we register.
REQ-023 Priority SHALL go to the core; the DMA SHALL win if c_req=0, or if defer_cnt==MAX_DEFER.
REQ-024 defer_cnt (4-bit) SHALL increment when m_req=1 and the core wins, clear when the DMA wins, and hold otherwise; it SHALL never exceed MAX_DEFER.
REQ-025 dwe SHALL be 1 only in P2 when the owner's we=1; it SHALL be 0 in P3 and in every other state.
REQ-026 daddr and din SHALL hold their latched values from P2 through the next P1->P2 update.
REQ-027 On the P3 edge, the owner's rdata register SHALL capture dout, for reads and writes alike.
REQ-028 The owner's ack SHALL pulse high in the cycle after P3, whether that cycle is P0 or HALT.
REQ-029 When owner=NONE, neither ack SHALL pulse, and both rdata registers SHALL hold.
REQ-030 c_stall SHALL be 1 during P2 and P3 when c_req was 1 at the P1 sample and the DMA won; otherwise it is 0.
REQ-031 Requesters SHALL hold req, we, addr, and wdata stable from assertion until ack; a request dropped before P1 is not served.
REQ-032 At most one transaction SHALL be served per 4-cycle rotation; the rotation latency from the P1 sample to ack is 3 cycles.

Reset
REQ-033 When rst=1 at an edge, the next state SHALL be HALT, owner NONE, defer_cnt 0.
REQ-034 After reset, all strobes, dwe, c_stall, c_ack, and m_ack SHALL be 0; phase, daddr, din, c_rdata, and m_rdata SHALL be 0.
REQ-035 Reset SHALL take priority over all other events; a transaction in flight SHALL be dropped with no ack, and dwe SHALL be 0 in the cycle after rst.

Verification
REQ-036 Apply rst, then run=1 held -> HALT for one cycle, then i1re, i2re, dre, gwe repeating with period 4 and phase 0,1,2,3.
REQ-037 Core write c_addr=0x0010, c_wdata=0xBEEF -> in P2, dwe=1, daddr=0x0010, din=0xBEEF; dwe=0 in P3; c_ack pulses in the next P0.
REQ-038 DMA read m_addr=0x0200 with memory model dout=0x1234 in P3 -> m_rdata=0x1234 and m_ack=1 in the following cycle; c_ack stays 0.
REQ-039 c_req and m_req held high with MAX_DEFER=4 -> the core wins 4 windows, the DMA wins the 5th with c_stall=1 in that window's P2/P3, and defer_cnt returns to 0; the pattern repeats.
REQ-040 run dropped during P1 -> P2 and P3 still occur with a pending ack delivered, then HALT with all strobes 0 and phase=0.
REQ-041 rst asserted in P2 during a core write -> next cycle HALT, dwe=0, no c_ack, outputs at their reset values.
